// File: rtl/hazard_stall_ctrl_if.sv
// D-stage hazard bundle between the pipeline and the stall controller.
// master = pipeline side, slave = stall controller.
interface hazard_stall_ctrl_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_Tuse_rs;
  logic [1:0] D_Tuse_rt;
  logic       D_md;
  logic [4:0] E_A3;
  logic [1:0] E_Tnew;
  logic [4:0] M_A3;
  logic [1:0] M_Tnew;
  logic       E_md_start;
  logic       E_md_div;
  logic       pc_we;
  logic       if_id_we;
  logic       id_ex_clr;
  logic       md_busy;
  logic       stall;

  modport master (
    output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_md,
    output E_A3, E_Tnew, M_A3, M_Tnew,
    output E_md_start, E_md_div,
    input  pc_we, if_id_we, id_ex_clr, md_busy, stall
  );

  modport slave (
    input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_md,
    input  E_A3, E_Tnew, M_A3, M_Tnew,
    input  E_md_start, E_md_div,
    output pc_we, if_id_we, id_ex_clr, md_busy, stall
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall controller: Tuse/Tnew data hazards plus mult/div busy window.
// HAZARD_STALL_CNT_EN adds saturating stall_cycles/md_stall_cycles counters.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  hazard_stall_ctrl_if.slave bus
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall;

  always_comb begin
    stall_rs = (bus.D_rs != 5'd0) &
      (((bus.D_rs == bus.E_A3) & (bus.D_Tuse_rs < bus.E_Tnew)) |
       ((bus.D_rs == bus.M_A3) & (bus.D_Tuse_rs < bus.M_Tnew)));
    stall_rt = (bus.D_rt != 5'd0) &
      (((bus.D_rt == bus.E_A3) & (bus.D_Tuse_rt < bus.E_Tnew)) |
       ((bus.D_rt == bus.M_A3) & (bus.D_Tuse_rt < bus.M_Tnew)));
    stall_md = bus.D_md & (bus.E_md_start | (cnt != '0));
    stall    = stall_rs | stall_rt | stall_md;
  end

  assign bus.md_busy   = (cnt != '0);
  assign bus.stall     = stall;
  assign bus.pc_we     = ~stall;
  assign bus.if_id_we  = ~stall;
  assign bus.id_ex_clr = stall;

  // A start seen while busy is dropped; the running count keeps going.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (bus.E_md_start && (cnt == '0)) begin
      cnt <= bus.E_md_div ? DIV_LD : MULT_LD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles    <= '0;
      md_stall_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (stall_md && (md_stall_cycles != 32'hFFFF_FFFF))
        md_stall_cycles <= md_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
